store_commit_unit: RTL and testbench

STORE_COMMIT_UNIT -- requirements
Module: store_commit_unit

---
 rtl/store_commit_unit.sv | 165 ++++++++++++++++
 tb/tb_store_commit_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_unit.sv
// rtl/store_commit_unit.sv - commits the ROB-head store to memory with lane shifting, timeout and error flags
//
// Purpose:
//   Takes the store at the head of the ROB, checks its alignment and
//   drives one write request with lane-shifted data and byte strobes. It
//   waits for the memory ack, or gives up after ACK_TIMEOUT cycles, and
//   then pulses store_read_out once so the ROB advances its head.
//
// Ports:
//   clk_in            rising-edge clock
//   rst_in            asynchronous active-low reset
//   store_valid_in    ROB head holds a ready store (level)
//   store_addr_in     store byte address
//   store_data_in     store data, LSB-aligned
//   store_size_in     00 byte, 01 half, 10 word, 11 illegal
//   store_read_out    one-cycle "head store done" pulse
//   mem_req_out       write request
//   mem_addr_out      word-aligned write address
//   mem_wdata_out     lane-shifted write data
//   mem_wstrb_out     byte enables (zero when not requesting)
//   mem_ack_in        memory accepted the write
//   busy_out          unit is not idle
//   misalign_err_out  sticky: misaligned or illegal-size store seen
//   timeout_err_out   sticky: ack timeout seen
//   store_count_out   saturating count of successfully written stores
module store_commit_unit #(
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             store_valid_in,
  input  logic [31:0]      store_addr_in,
  input  logic [31:0]      store_data_in,
  input  logic [1:0]       store_size_in,
  output logic             store_read_out,
  output logic             mem_req_out,
  output logic [31:0]      mem_addr_out,
  output logic [31:0]      mem_wdata_out,
  output logic [3:0]       mem_wstrb_out,
  input  logic             mem_ack_in,
  output logic             busy_out,
  output logic             misalign_err_out,
  output logic             timeout_err_out,
  output logic [CNT_W-1:0] store_count_out
);

  localparam int            TW    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RETIRE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [1:0]       r_size;
  logic [TW-1:0]    r_cyc;
  logic             r_misalign;
  logic             r_timeout;
  logic [CNT_W-1:0] r_count;

  logic             w_legal;
  logic             w_in_req;
  logic             w_timeout_hit;
  logic [3:0]       w_mask;
  logic [3:0]       w_strb_sh;
  logic [31:0]      w_wdata_sh;

  // Legality is judged on the incoming store so an illegal one can skip REQ.
  always_comb begin
    w_legal = 1'b0;
    case (store_size_in)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~store_addr_in[0];
      2'b10:   w_legal = (store_addr_in[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_mask = 4'b1111;
    case (r_size)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_in_req      = (r_state == ST_REQ);
  // Ack wins over timeout when both land in the last allowed cycle.
  assign w_timeout_hit = w_in_req && !mem_ack_in && (r_cyc == TLAST);
  assign w_strb_sh     = w_mask << r_addr[1:0];
  assign w_wdata_sh    = r_data << {r_addr[1:0], 3'b000};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    mem_req_out    = 1'b0;
    store_read_out = 1'b0;
    busy_out       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy_out = 1'b0;
        if (store_valid_in) w_state_nxt = w_legal ? ST_REQ : ST_RETIRE;
      end
      ST_REQ: begin
        mem_req_out = 1'b1;
        if (mem_ack_in || w_timeout_hit) w_state_nxt = ST_RETIRE;
      end
      ST_RETIRE: begin
        // No capture here: the ROB head only advances after this pulse.
        store_read_out = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        busy_out    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_size     <= '0;
      r_cyc      <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      r_count    <= '0;
    end else begin
      if (r_state == ST_IDLE && store_valid_in) begin
        r_addr <= store_addr_in;
        r_data <= store_data_in;
        r_size <= store_size_in;
        if (!w_legal) r_misalign <= 1'b1;
      end
      // Held at zero in IDLE, so it is always clear on entry to REQ.
      if (r_state == ST_IDLE)  r_cyc <= '0;
      else if (w_in_req)       r_cyc <= r_cyc + TW'(1);
      if (w_in_req && mem_ack_in) begin
        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign mem_addr_out     = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata_out    = w_in_req ? w_wdata_sh : 32'd0;
  assign mem_wstrb_out    = w_in_req ? w_strb_sh : 4'd0;
  assign misalign_err_out = r_misalign;
  assign timeout_err_out  = r_timeout;
  assign store_count_out  = r_count;

endmodule

// File: tb/tb_store_commit_unit.sv
// tb/tb_store_commit_unit.sv - directed self-checking bench for store_commit_unit
module tb_store_commit_unit;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] data;
  logic [1:0]  size;
  logic        ack;

  logic        d_read, d_req, d_busy, d_mis, d_to;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_strb;
  logic [1:0]  d_count;

  logic        t_valid;
  logic        t_ack;
  logic        t_read, t_req, t_busy, t_mis, t_to;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_strb;
  logic [15:0] t_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Narrow counter so saturation is reached during the back-to-back run.
  store_commit_unit #(.ACK_TIMEOUT(64), .CNT_W(2)) u_dut (
    .clk_in(clk), .rst_in(rst_n), .store_valid_in(valid),
    .store_addr_in(addr), .store_data_in(data), .store_size_in(size),
    .store_read_out(d_read), .mem_req_out(d_req), .mem_addr_out(d_addr),
    .mem_wdata_out(d_wdata), .mem_wstrb_out(d_strb), .mem_ack_in(ack),
    .busy_out(d_busy), .misalign_err_out(d_mis), .timeout_err_out(d_to),
    .store_count_out(d_count)
  );

  store_commit_unit #(.ACK_TIMEOUT(4), .CNT_W(16)) u_to (
    .clk_in(clk), .rst_in(rst_n), .store_valid_in(t_valid),
    .store_addr_in(addr), .store_data_in(data), .store_size_in(size),
    .store_read_out(t_read), .mem_req_out(t_req), .mem_addr_out(t_addr),
    .mem_wdata_out(t_wdata), .mem_wstrb_out(t_strb), .mem_ack_in(t_ack),
    .busy_out(t_busy), .misalign_err_out(t_mis), .timeout_err_out(t_to),
    .store_count_out(t_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] b2b_addr [0:3];
  logic [31:0] b2b_data [0:3];

  initial begin
    b2b_addr[0] = 32'h0000_6000; b2b_data[0] = 32'h1111_1111;
    b2b_addr[1] = 32'h0000_6004; b2b_data[1] = 32'h2222_2222;
    b2b_addr[2] = 32'h0000_6008; b2b_data[2] = 32'h3333_3333;
    b2b_addr[3] = 32'h0000_600C; b2b_data[3] = 32'h4444_4444;

    rst_n = 1'b0; valid = 1'b0; addr = '0; data = '0; size = '0; ack = 1'b0;
    t_valid = 1'b0; t_ack = 1'b0;
    step(); step();
    check("rst_req",   {31'd0, d_req},  32'd0);
    check("rst_busy",  {31'd0, d_busy}, 32'd0);
    check("rst_read",  {31'd0, d_read}, 32'd0);
    check("rst_count", {30'd0, d_count}, 32'd0);
    check("rst_errs",  {30'd0, d_mis, d_to}, 32'd0);
    rst_n = 1'b1;
    step();

    // Word store, ack in the first REQ cycle.
    valid = 1'b1; addr = 32'h0000_1004; data = 32'hDEAD_BEEF; size = 2'b10;
    step();
    check("sw_req",   {31'd0, d_req},  32'd1);
    check("sw_addr",  d_addr,          32'h0000_1004);
    check("sw_strb",  {28'd0, d_strb}, 32'hF);
    check("sw_wdata", d_wdata,         32'hDEAD_BEEF);
    check("sw_read0", {31'd0, d_read}, 32'd0);
    valid = 1'b0; ack = 1'b1;
    step();
    check("sw_read1", {31'd0, d_read}, 32'd1);
    check("sw_req_off", {31'd0, d_req}, 32'd0);
    check("sw_strb_off", {28'd0, d_strb}, 32'd0);
    check("sw_count", {30'd0, d_count}, 32'd1);
    step();
    check("sw_read_end", {31'd0, d_read}, 32'd0);
    check("sw_idle", {31'd0, d_busy}, 32'd0);

    // Ack while idle must be ignored.
    step();
    check("idle_ack_busy",  {31'd0, d_busy},  32'd0);
    check("idle_ack_count", {30'd0, d_count}, 32'd1);
    ack = 1'b0;

    // Byte store to lane 3, ack in the 5th REQ cycle; valid drops mid-REQ.
    valid = 1'b1; addr = 32'h0000_2003; data = 32'h0000_00AB; size = 2'b00;
    step();
    valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("sb_req",   {31'd0, d_req},  32'd1);
      check("sb_addr",  d_addr,          32'h0000_2000);
      check("sb_strb",  {28'd0, d_strb}, 32'h8);
      check("sb_wdata", d_wdata,         32'hAB00_0000);
      check("sb_read0", {31'd0, d_read}, 32'd0);
      if (i == 5) ack = 1'b1;
      step();
    end
    ack = 1'b0;
    check("sb_read1", {31'd0, d_read},  32'd1);
    check("sb_count", {30'd0, d_count}, 32'd2);
    step();
    check("sb_read_end", {31'd0, d_read}, 32'd0);

    // Misaligned half store: goes straight to RETIRE, no request.
    valid = 1'b1; addr = 32'h0000_3001; data = 32'h0000_BEEF; size = 2'b01;
    check("sh_mis_before", {31'd0, d_mis}, 32'd0);
    step();
    valid = 1'b0;
    check("sh_req",   {31'd0, d_req},  32'd0);
    check("sh_strb",  {28'd0, d_strb}, 32'd0);
    check("sh_read",  {31'd0, d_read}, 32'd1);
    check("sh_mis",   {31'd0, d_mis},  32'd1);
    check("sh_count", {30'd0, d_count}, 32'd2);
    step();
    check("sh_read_end", {31'd0, d_read}, 32'd0);
    check("sh_mis_sticky", {31'd0, d_mis}, 32'd1);

    // Back-to-back legal stores with valid and ack held high; count saturates at 3.
    valid = 1'b1; ack = 1'b1; size = 2'b10;
    addr = b2b_addr[0]; data = b2b_data[0];
    for (int k = 0; k < 3; k++) begin
      step();
      check("b2b_req",   {31'd0, d_req}, 32'd1);
      check("b2b_addr",  d_addr,         b2b_addr[k]);
      check("b2b_wdata", d_wdata,        b2b_data[k]);
      step();
      check("b2b_read",  {31'd0, d_read}, 32'd1);
      check("b2b_count", {30'd0, d_count}, 32'd3);
      addr = b2b_addr[k+1]; data = b2b_data[k+1];
      step();
      check("b2b_gap_read", {31'd0, d_read}, 32'd0);
      check("b2b_gap_req",  {31'd0, d_req},  32'd0);
      check("b2b_gap_busy", {31'd0, d_busy}, 32'd0);
    end
    valid = 1'b0; ack = 1'b0;
    step();
    check("b2b_sat", {30'd0, d_count}, 32'd3);
    check("no_timeout_main", {31'd0, d_to}, 32'd0);

    // Timeout on the ACK_TIMEOUT=4 instance.
    t_valid = 1'b1; addr = 32'h0000_4008; data = 32'h1234_5678; size = 2'b10;
    step();
    t_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("to_req",    {31'd0, t_req},  32'd1);
      check("to_read0",  {31'd0, t_read}, 32'd0);
      check("to_flag0",  {31'd0, t_to},   32'd0);
      step();
    end
    check("to_req_off", {31'd0, t_req}, 32'd0);
    check("to_read1",   {31'd0, t_read}, 32'd1);
    check("to_flag",    {31'd0, t_to},   32'd1);
    check("to_count",   {16'd0, t_count}, 32'd0);
    step();
    check("to_read_end", {31'd0, t_read}, 32'd0);
    check("to_flag_sticky", {31'd0, t_to}, 32'd1);

    // Asynchronous reset in the middle of a REQ cycle.
    valid = 1'b1; addr = 32'h0000_5000; data = 32'hCAFE_F00D; size = 2'b10;
    step();
    check("ar_req_pre", {31'd0, d_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req",   {31'd0, d_req},  32'd0);
    check("ar_busy",  {31'd0, d_busy}, 32'd0);
    check("ar_strb",  {28'd0, d_strb}, 32'd0);
    check("ar_addr",  d_addr,          32'd0);
    check("ar_count", {30'd0, d_count}, 32'd0);
    check("ar_errs",  {28'd0, d_mis, d_to, t_mis, t_to}, 32'd0);
    step();
    check("ar_hold_read", {31'd0, d_read}, 32'd0);
    check("ar_hold_req",  {31'd0, d_req},  32'd0);
    step();
    rst_n = 1'b1;
    check("ar_rel_busy", {31'd0, d_busy}, 32'd0);
    step();
    check("ar_cap_req",  {31'd0, d_req}, 32'd1);
    check("ar_cap_addr", d_addr,         32'h0000_5000);
    valid = 1'b0; ack = 1'b1;
    step();
    ack = 1'b0;
    check("ar_read",  {31'd0, d_read},  32'd1);
    check("ar_count1", {30'd0, d_count}, 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
